instruction_fetch: RTL and testbench

//  Fetch stage of the 5-stage MIPS pipeline. Owns the program counter and drives it to the

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/next_pc_select.sv | 33 +++
 rtl/instruction_fetch.sv | 88 ++++++++
 tb/tb_instruction_fetch.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the MIPS instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 26;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] jump_addr(input logic [XLEN-1:0]  pc4,
                                                input logic [IDX_W-1:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Priority mux for the next fetch address; flags taken jumps/branches as a redirect.
module next_pc_select
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  if_id_pcplus4,
  input  logic             fault_state,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [IDX_W-1:0] jump_index,
  output logic [XLEN-1:0]  next_pc_c,
  output logic             redirect_c
);

  always_comb begin
    next_pc_c  = pc + 32'd4;
    redirect_c = 1'b0;
    if (fault_state) begin
      next_pc_c = pc;
    end else if (jump) begin
      next_pc_c  = jump_addr(if_id_pcplus4, jump_index);
      redirect_c = 1'b1;
    end else if (branch_taken) begin
      next_pc_c  = branch_target;
      redirect_c = 1'b1;
    end else if (stall) begin
      next_pc_c = pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC register, IF/ID register and the RUN/FAULT state machine.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IM_SIZE    = 1024,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [IDX_W-1:0] jump_index,
  output logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  Instruction,
  output logic [XLEN-1:0]  IF_ID_Instruction,
  output logic [XLEN-1:0]  IF_ID_PCPlus4,
  output logic             IF_ID_Valid,
  output logic             fetch_fault
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IM_SIZE - 4);
  localparam if_id_t          IF_ID_NOP = '{instr: NOP_INSTR, pcplus4: '0, valid: 1'b0};

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  if_id_t          if_id_q;
  logic            fault_q;

  logic [XLEN-1:0] next_pc_c;
  logic            redirect_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic            illegal_c;
  logic            take_fault_c;
  if_id_t          fetched_c;

  next_pc_select u_next_pc (
    .pc            (pc_q),
    .if_id_pcplus4 (if_id_q.pcplus4),
    .fault_state   (state_q == FETCH_FAULT),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .next_pc_c     (next_pc_c),
    .redirect_c    (redirect_c)
  );

  // A stall that is not overridden by a redirect defers the fault check
  always_comb begin
    pc_plus4_c   = pc_q + 32'd4;
    illegal_c    = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);
    take_fault_c = illegal_c && (!stall || redirect_c);
    fetched_c    = '{instr: Instruction, pcplus4: pc_plus4_c, valid: 1'b1};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
      if_id_q <= IF_ID_NOP;
      fault_q <= 1'b0;
    end else if (state_q == FETCH_FAULT) begin
      if_id_q <= IF_ID_NOP;
    end else if (take_fault_c) begin
      state_q <= FETCH_FAULT;
      fault_q <= 1'b1;
      if_id_q <= IF_ID_NOP;
    end else begin
      pc_q <= next_pc_c;
      if (redirect_c) begin
        if_id_q <= DELAY_SLOT ? fetched_c : IF_ID_NOP;
      end else if (!stall) begin
        if_id_q <= fetched_c;
      end
    end
  end

  assign PC                = pc_q;
  assign IF_ID_Instruction = if_id_q.instr;
  assign IF_ID_PCPlus4     = if_id_q.pcplus4;
  assign IF_ID_Valid       = if_id_q.valid;
  assign fetch_fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed cycles push expectations, a monitor checks them.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;

  logic [31:0] pc0, ins0, ifi0, p40;
  logic        v0, f0;
  logic [31:0] pc1, ins1, ifi1, p41;
  logic        v1, f1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] ifi;
    logic [31:0] p4;
    logic        v;
    logic        f;
    bit          h1;
    logic [31:0] ifi1;
    logic [31:0] p41;
    logic        v1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Instruction memory model: word k holds (k+1)*0x11111111
  function automatic logic [31:0] w(input logic [31:0] a);
    logic [31:0] k;
    k = {2'b00, a[31:2]} + 32'd1;
    return 32'(32'h1111_1111 * k);
  endfunction

  assign ins0 = w(pc0);
  assign ins1 = w(pc1);

  instruction_fetch #(.RESET_PC(32'h0), .IM_SIZE(1024), .DELAY_SLOT(1'b0)) dut0 (
    .clock(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .PC(pc0), .Instruction(ins0), .IF_ID_Instruction(ifi0), .IF_ID_PCPlus4(p40),
    .IF_ID_Valid(v0), .fetch_fault(f0)
  );

  instruction_fetch #(.RESET_PC(32'h0), .IM_SIZE(1024), .DELAY_SLOT(1'b1)) dut1 (
    .clock(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .PC(pc1), .Instruction(ins1), .IF_ID_Instruction(ifi1), .IF_ID_PCPlus4(p41),
    .IF_ID_Valid(v1), .fetch_fault(f1)
  );

  task automatic cyc(input bit rst, input bit st, input bit bt, input logic [31:0] bta,
                     input bit j, input logic [25:0] ji,
                     input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ep4,
                     input bit ev, input bit ef, input string nm,
                     input bit h1 = 1'b0, input logic [31:0] ei1 = 32'h0,
                     input logic [31:0] ep41 = 32'h0, input bit ev1 = 1'b0);
    exp_t e;
    @(negedge clk);
    reset         = ~rst;
    stall         = st;
    branch_taken  = bt;
    branch_target = bta;
    jump          = j;
    jump_index    = ji;
    e = '{nm: nm, pc: epc, ifi: ei, p4: ep4, v: ev, f: ef,
          h1: h1, ifi1: ei1, p41: ep41, v1: ev1};
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic free(input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ep4,
                      input string nm);
    cyc(0, 0, 0, 32'h0, 0, 26'h0, epc, ei, ep4, 1'b1, 1'b0, nm);
  endtask

  // Monitor: every edge with a pending expectation is compared 1 time unit later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({pc0, ifi0, p40, v0, f0} !== {e.pc, e.ifi, e.p4, e.v, e.f}) begin
          failures++;
          $display("FAIL %s: got pc=%h ifi=%h p4=%h v=%b f=%b, want pc=%h ifi=%h p4=%h v=%b f=%b",
                   e.nm, pc0, ifi0, p40, v0, f0, e.pc, e.ifi, e.p4, e.v, e.f);
        end
        if (e.h1) begin
          checks++;
          if ({pc1, ifi1, p41, v1, f1} !== {e.pc, e.ifi1, e.p41, e.v1, e.f}) begin
            failures++;
            $display("FAIL %s_ds1: got pc=%h ifi=%h p4=%h v=%b f=%b, want pc=%h ifi=%h p4=%h v=%b f=%b",
                     e.nm, pc1, ifi1, p41, v1, f1, e.pc, e.ifi1, e.p41, e.v1, e.f);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;

    cyc(1, 0, 0, 32'h0, 0, 26'h0, 32'h0, 32'h0, 32'h0, 0, 0, "reset_a");
    cyc(1, 1, 1, 32'h80, 1, 26'h3, 32'h0, 32'h0, 32'h0, 0, 0, "reset_b");

    // Free run and stall
    free(32'h4, w(32'h0), 32'h4, "run1");
    free(32'h8, w(32'h4), 32'h8, "run2");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 32'h0, 0, 26'h0, 32'h8, w(32'h4), 32'h8, 1, 0, "stall_hold");
    free(32'hC, w(32'h8), 32'hC, "stall_release");
    free(32'h10, w(32'hC), 32'h10, "run3");

    // Branch: DELAY_SLOT=0 squashes, DELAY_SLOT=1 keeps the word at 0x10
    cyc(0, 0, 1, 32'h40, 0, 26'h0, 32'h40, 32'h0, 32'h0, 0, 0, "branch",
        1'b1, w(32'h10), 32'h14, 1'b1);
    free(32'h44, w(32'h40), 32'h44, "after_branch");

    // Jump beats branch, also with stall asserted
    cyc(0, 0, 1, 32'h4, 0, 26'h0, 32'h4, 32'h0, 32'h0, 0, 0, "br4_a");
    free(32'h8, w(32'h4), 32'h8, "pc8_a");
    cyc(0, 0, 1, 32'h100, 1, 26'h10, 32'h40, 32'h0, 32'h0, 0, 0, "jump_pri");
    cyc(0, 0, 1, 32'h4, 0, 26'h0, 32'h4, 32'h0, 32'h0, 0, 0, "br4_b");
    free(32'h8, w(32'h4), 32'h8, "pc8_b");
    cyc(0, 1, 1, 32'h100, 1, 26'h10, 32'h40, 32'h0, 32'h0, 0, 0, "jump_stall");
    free(32'h44, w(32'h40), 32'h44, "after_jump");

    // Misaligned redirect target faults one edge later and freezes
    cyc(0, 0, 1, 32'h402, 0, 26'h0, 32'h402, 32'h0, 32'h0, 0, 0, "br_misaligned");
    cyc(0, 0, 0, 32'h0, 0, 26'h0, 32'h402, 32'h0, 32'h0, 0, 1, "fault_taken");
    for (int i = 0; i < 10; i++)
      cyc(0, i[0], i[1], 32'h80, (i % 3) == 0, 26'h5, 32'h402, 32'h0, 32'h0, 0, 1, "fault_hold");
    cyc(1, 0, 1, 32'h80, 0, 26'h0, 32'h0, 32'h0, 32'h0, 0, 0, "fault_reset");

    // Last legal word then out-of-range fault
    cyc(0, 0, 1, 32'h3F8, 0, 26'h0, 32'h3F8, 32'h0, 32'h0, 0, 0, "br_3f8");
    free(32'h3FC, w(32'h3F8), 32'h3FC, "pc_3fc");
    free(32'h400, w(32'h3FC), 32'h400, "last_legal");
    cyc(0, 0, 0, 32'h0, 0, 26'h0, 32'h400, 32'h0, 32'h0, 0, 1, "oob_fault");
    cyc(1, 0, 1, 32'h80, 1, 26'h7, 32'h0, 32'h0, 32'h0, 0, 0, "reset_redirect");
    free(32'h4, w(32'h0), 32'h4, "post_reset");

    @(negedge clk);
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
